pc_unit: RTL and testbench

PC_UNIT -- requirements
Module: pc_unit

---
 rtl/pc_unit_if.sv | 35 +++
 rtl/pc_unit.sv | 78 +++++++
 tb/tb_pc_unit.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/pc_unit_if.sv
// pc_unit_if -- request/status bundle between the fetch logic and pc_unit.
//   master : drives stall/branch/offset/jump/call/ret/target, observes status
//   slave  : pc_unit side; receives requests, drives pc, pc_plus and
//            return-address-stack status (ras_count/empty/full/ovf/unf)
interface pc_unit_if #(
    parameter int WIDTH     = 32,
    parameter int RAS_DEPTH = 4
);
    localparam int CW = $clog2(RAS_DEPTH) + 1;

    logic             stall;
    logic             branch;
    logic [WIDTH-1:0] offset;
    logic             jump;
    logic             call;
    logic             ret;
    logic [WIDTH-1:0] target;
    logic [WIDTH-1:0] pc;
    logic [WIDTH-1:0] pc_plus;
    logic [CW-1:0]    ras_count;
    logic             ras_empty;
    logic             ras_full;
    logic             ras_ovf;
    logic             ras_unf;

    modport master (
        output stall, branch, offset, jump, call, ret, target,
        input  pc, pc_plus, ras_count, ras_empty, ras_full, ras_ovf, ras_unf
    );

    modport slave (
        input  stall, branch, offset, jump, call, ret, target,
        output pc, pc_plus, ras_count, ras_empty, ras_full, ras_ovf, ras_unf
    );
endinterface

// File: rtl/pc_unit.sv
// pc_unit -- program counter with a circular return-address stack.
// All state updates on the falling edge of clk.
//   clk   : clock (state changes on negedge)
//   reset : synchronous active-high reset, sampled on the falling edge
//   bus   : pc_unit_if.slave -- requests in (stall, ret, call, jump, branch
//           with offset/target), pc/pc_plus and stack status out
// Request priority: reset, stall, ret, call, jump, branch, sequential.
module pc_unit #(
    parameter int               WIDTH      = 32,
    parameter int               STEP       = 1,
    parameter logic [WIDTH-1:0] RESET_ADDR = '0,
    parameter int               RAS_DEPTH  = 4
) (
    input logic       clk,
    input logic       reset,
    pc_unit_if.slave  bus
);
    localparam int AW = $clog2(RAS_DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] pc_q;
    logic [WIDTH-1:0] pc_plus;
    logic [WIDTH-1:0] stack [RAS_DEPTH];
    // ptr is the next write slot; it wraps freely so a push onto a full
    // stack overwrites the oldest entry and the newest ones stay in order.
    logic [AW-1:0]    ptr;
    logic [AW-1:0]    ptr_dec;
    logic [CW-1:0]    count;
    logic             full;
    logic             ovf;
    logic             unf;

    assign pc_plus = pc_q + WIDTH'(STEP);
    assign ptr_dec = ptr - AW'(1);
    assign full    = (count == CW'(RAS_DEPTH));

    always_ff @(negedge clk) begin
        if (reset) begin
            pc_q  <= RESET_ADDR;
            ptr   <= '0;
            count <= '0;
            ovf   <= 1'b0;
            unf   <= 1'b0;
        end else if (!bus.stall) begin
            if (bus.ret) begin
                if (count != '0) begin
                    pc_q  <= stack[ptr_dec];
                    ptr   <= ptr_dec;
                    count <= count - CW'(1);
                end else begin
                    // return with nothing to return to: fall through
                    pc_q <= pc_plus;
                    unf  <= 1'b1;
                end
            end else if (bus.call) begin
                stack[ptr] <= pc_plus;
                ptr        <= ptr + AW'(1);
                if (full) ovf   <= 1'b1;
                else      count <= count + CW'(1);
                pc_q <= bus.target;
            end else if (bus.jump) begin
                pc_q <= bus.target;
            end else if (bus.branch) begin
                pc_q <= pc_q + bus.offset;
            end else begin
                pc_q <= pc_plus;
            end
        end
    end

    assign bus.pc        = pc_q;
    assign bus.pc_plus   = pc_plus;
    assign bus.ras_count = count;
    assign bus.ras_empty = (count == '0);
    assign bus.ras_full  = full;
    assign bus.ras_ovf   = ovf;
    assign bus.ras_unf   = unf;
endmodule

// File: tb/tb_pc_unit.sv
// tb_pc_unit -- directed + randomized bench for pc_unit (WIDTH=32, STEP=1,
// RESET_ADDR=0, RAS_DEPTH=4). Reference model: pc variable plus a queue of
// return addresses (back = most recent).
module tb_pc_unit;
    localparam int WIDTH = 32;
    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    pc_unit_if #(.WIDTH(WIDTH), .RAS_DEPTH(DEPTH)) bus ();

    pc_unit #(
        .WIDTH(WIDTH), .STEP(1), .RESET_ADDR('0), .RAS_DEPTH(DEPTH)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    // reference model state
    logic [31:0] m_pc;
    logic [31:0] m_q[$];
    logic        m_ovf, m_unf;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h (check %0d)", tag, obs, exp, checks);
        end
    endtask

    task automatic drive(input logic rs, input logic st, input logic cl, input logic jp,
                         input logic rt, input logic br, input logic [31:0] off,
                         input logic [31:0] tg);
        reset      = rs;
        bus.stall  = st;
        bus.call   = cl;
        bus.jump   = jp;
        bus.ret    = rt;
        bus.branch = br;
        bus.offset = off;
        bus.target = tg;
    endtask

    task automatic model_step();
        if (reset) begin
            m_pc = 32'h0; m_q.delete(); m_ovf = 1'b0; m_unf = 1'b0;
        end else if (bus.stall) begin
            // hold everything
        end else if (bus.ret) begin
            if (m_q.size() > 0) m_pc = m_q.pop_back();
            else begin m_pc = m_pc + 32'd1; m_unf = 1'b1; end
        end else if (bus.call) begin
            if (m_q.size() == DEPTH) begin void'(m_q.pop_front()); m_ovf = 1'b1; end
            m_q.push_back(m_pc + 32'd1);
            m_pc = bus.target;
        end else if (bus.jump) begin
            m_pc = bus.target;
        end else if (bus.branch) begin
            m_pc = m_pc + bus.offset;
        end else begin
            m_pc = m_pc + 32'd1;
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".pc"},      bus.pc, m_pc);
        chk({tag, ".pc_plus"}, bus.pc_plus, m_pc + 32'd1);
        chk({tag, ".count"},   32'(bus.ras_count), 32'(m_q.size()));
        chk({tag, ".empty"},   32'(bus.ras_empty), 32'(m_q.size() == 0));
        chk({tag, ".full"},    32'(bus.ras_full), 32'(m_q.size() == DEPTH));
        chk({tag, ".ovf"},     32'(bus.ras_ovf), 32'(m_ovf));
        chk({tag, ".unf"},     32'(bus.ras_unf), 32'(m_unf));
    endtask

    // one falling edge with the currently driven inputs, then compare
    task automatic tick(input string tag);
        @(negedge clk);
        #1;
        model_step();
        check_all(tag);
    endtask

    initial begin
        logic [31:0] rets [5];
        m_pc = '0; m_ovf = 1'b0; m_unf = 1'b0;
        drive(1, 0, 0, 0, 0, 0, 0, 0);
        @(posedge clk);
        tick("reset");
        chk("reset.pc_const", bus.pc, 32'h0);

        // idle counting
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 1; i <= 3; i++) begin
            tick("idle");
            chk("idle.pc_const", bus.pc, 32'(i));
        end

        // negative branch and wraparound
        drive(0, 0, 0, 1, 0, 0, 0, 32'h10);         tick("jmp10");
        drive(0, 0, 0, 0, 0, 1, 32'hFFFF_FFFC, 0);  tick("brneg");
        chk("brneg.const", bus.pc, 32'h0C);
        drive(0, 0, 0, 1, 0, 0, 0, 32'hFFFF_FFFF);  tick("jmpmax");
        drive(0, 0, 0, 0, 0, 0, 0, 0);              tick("wrap");
        chk("wrap.const", bus.pc, 32'h0);

        // call / ret round trip
        drive(0, 0, 0, 1, 0, 0, 0, 32'h20);         tick("jmp20");
        drive(0, 0, 1, 0, 0, 0, 0, 32'h100);        tick("call100");
        chk("call100.const", bus.pc, 32'h100);
        drive(0, 0, 0, 0, 1, 0, 0, 0);              tick("ret21");
        chk("ret21.const", bus.pc, 32'h21);

        // five nested calls overflow a 4-deep stack
        for (int i = 0; i < 5; i++) begin
            rets[i] = bus.pc + 32'd1;
            drive(0, 0, 1, 0, 0, 0, 0, 32'h1000 * (i + 1));
            tick("ncall");
        end
        chk("ovf.const", 32'(bus.ras_ovf), 32'd1);
        for (int i = 4; i >= 1; i--) begin
            drive(0, 0, 0, 0, 1, 0, 0, 0);
            tick("nret");
            chk("nret.const", bus.pc, rets[i]);
        end
        drive(0, 0, 0, 0, 1, 0, 0, 0);              tick("unf");
        chk("unf.const", 32'(bus.ras_unf), 32'd1);

        // stall beats call and jump; then call beats jump
        drive(1, 0, 0, 0, 0, 0, 0, 0);              tick("rst2");
        drive(0, 0, 0, 1, 0, 0, 0, 32'h40);         tick("jmp40");
        drive(0, 1, 1, 1, 0, 1, 32'h8, 32'h200);    tick("stall");
        chk("stall.const", bus.pc, 32'h40);
        drive(0, 0, 1, 1, 0, 1, 32'h8, 32'h200);    tick("callwins");
        chk("callwins.const", 32'(bus.ras_count), 32'd1);

        // reset with stack populated and ret pending
        drive(0, 0, 1, 0, 0, 0, 0, 32'h300);        tick("c2");
        drive(0, 0, 1, 0, 0, 0, 0, 32'h400);        tick("c3");
        drive(1, 0, 0, 0, 1, 0, 0, 0);              tick("rstret");
        chk("rstret.const", 32'(bus.ras_count), 32'd0);
        drive(0, 0, 0, 0, 1, 0, 0, 0);              tick("retafter");
        chk("retafter.const", 32'(bus.ras_unf), 32'd1);

        // randomized traffic
        for (int n = 0; n < 400; n++) begin
            drive(($urandom_range(0, 49) == 0), ($urandom_range(0, 5) == 0),
                  ($urandom_range(0, 3) == 0), ($urandom_range(0, 4) == 0),
                  ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0),
                  $urandom, $urandom);
            tick("rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
